xd_skip_mul: RTL and testbench
==============================

// Module: xd_skip_mul
// PURPOSE
//  Computes the Mamba-2 D-skip term xD[b,h,p] = D[h] * x[b,h,p] in FP16 for all B*H*P elements.
//  Sits directly upstream of the y residual adder: xD_flat feeds its xD input, done feeds its start2.
//  Runs as a start/done batch engine with PAR_P lanes of pipelined FP16 multipliers (fp16_mul_wrapper).
// PARAMETERS
//  B      1   batch count
//  H      4   head count
//  P      4   head dimension
//  DW     16  element width (FP16)
//  M_LAT  6   fp16_mul_wrapper latency, valid_in to valid_out, in cycles
//  PAR_P  4   parallel multiplier lanes along p, 1..P
// PORTS
//  clk        in   1          clock, rising edge
//  rst        in   1          reset, asynchronous, active-high
//  start      in   1          begin batch; sampled only in IDLE
//  x_flat     in   B*H*P*DW   x, element g=b*H*P+h*P+p at bits [(g+1)*DW-1 -: DW]
//  D_flat     in   H*DW       D per head, element h at bits [(h+1)*DW-1 -: DW]
//  xD_flat    out  B*H*P*DW   products, same packing as x_flat; registered
//  done       out  1          one-cycle pulse when every xD element is written
// BEHAVIOUR
//  Reset: state=IDLE, done=0, all xD elements=0, b/h/p counters=0, lane valids=0, tag pipes cleared.
//  FSM: IDLE -start-> CALC -last beat issued-> FLUSH -last result written-> DONE -> IDLE (DONE lasts one cycle).
//  - done=1 only in the cycle after DONE is entered; 0 in every other cycle.
//  CALC issue: one beat per cycle, p advancing by PAR_P, then h, then b.
//  - Beat count N = B*H*ceil(P/PAR_P).
//  - Lane i takes operand pair (D[h], x[b,h,p+i]) with per-lane valid = (p+i < P).
//  - Masked lanes (p+i >= P) never write xD and never index out of range.
//  Tagging: each lane carries {valid, b, h, p+i} through a shift pipe matched to operand reg + M_LAT.
//  - A result is written to xD[tag] only when the wrapper valid_out and the tag valid are both 1.
//  - Index is recomputed from the tag, never from the live counters.
//  - The tag pipe keeps shifting in FLUSH, with valid=0 shifted in.
//  Latency: start sampled at edge t -> done high in cycle t+N+M_LAT+3; bench checks this exact count.
//  Arithmetic: IEEE-754 binary16 product from fp16_mul_wrapper, round-to-nearest-even.
//  - No extra rounding or saturation outside the optional FTZ below.
//  Inputs: x_flat/D_flat held stable from start until done; behaviour is undefined otherwise.
//  xD_flat: holds the last batch's values until overwritten by the next batch.
//  - A new batch rewrites every element; no clearing at start.
//  Simultaneous events:
//  - start while not in IDLE (including the DONE cycle) is ignored; no queueing.
//  - start in the IDLE cycle immediately after done starts a new batch.
//  Reset mid-operation: immediate return to IDLE; xD zeroed; done=0; in-flight multiplier results discarded.
//  - In-flight results are discarded because tag valids are cleared.
//  Edge cases:
//  - PAR_P >= P: one beat per (b,h), lanes >= P masked.
//  - B=H=1, P<=PAR_P: N=1, FSM path unchanged.
// CONFIGURATION
//  XD_FTZ_EN defined:
//  - Any product whose exponent field [14:10]==0 is written as {sign,15'b0}, i.e. subnormals flushed to signed zero.
//  - Applied at the write stage; adds no latency.
//  XD_FTZ_EN undefined: the multiplier result is written unmodified, subnormals included.
// TESTING
//  1 B=1,H=4,P=4,PAR_P=4, D=0x4000 (2.0), all x=0x3C00 (1.0) -> all xD=0x4000.
//    Single done pulse at t+4+M_LAT+3.
//  2 D[h]=0xBC00 (-1.0), x[0,h,p]=0x4200 (3.0) -> xD=0xC200 (-3.0).
//    Also D[2]=0x0000 -> xD[0,2,*]=0x0000.
//  3 P=6, PAR_P=4, x[p]=p as FP16, D=0x3C00 -> xD[p]=x[p] for p=0..5.
//    N=2*H beats; no X/out-of-range writes from lanes 2,3 on odd beats.
//  4 Assert start again in CALC, FLUSH and DONE -> ignored: exactly one done pulse, values as test 1.
//    start the cycle after done -> second batch completes correctly.
//  5 rst pulse mid-CALC -> same cycle: xD=0, done=0, state IDLE.
//    No done pulse and no xD writes for M_LAT+3 cycles after release without start.
//  6 D=0x0400 (2^-14), x=0x3800 (0.5):
//    XD_FTZ_EN undefined -> xD=0x0200.
//    XD_FTZ_EN defined -> xD=0x0000; D=0x8400 -> 0x8000.

Source files
------------

// File: rtl/xd_skip_mul.sv
// Mamba-2 D-skip term xD[b,h,p] = D[h] * x[b,h,p] in FP16, start/done batch engine with PAR_P lanes.
// Optional XD_FTZ_EN: products with a zero exponent field are flushed to signed zero at the write stage.

module fp16_mul_wrapper #(
    parameter int M_LAT = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic [15:0] a_in,
    input  logic [15:0] b_in,
    output logic        valid_out,
    output logic [15:0] prod_out
);
    // IEEE binary16 product, round-to-nearest-even, subnormals in and out.
    function automatic logic [15:0] fp16_mul(input logic [15:0] a, input logic [15:0] b);
        logic        sgn;
        logic [31:0] prod, n, rem, half;
        int          ea, eb, k, ee, rs;
        logic [15:0] r;
        sgn  = a[15] ^ b[15];
        ea   = (a[14:10] == 5'd0) ? 32'sd1 : int'(a[14:10]);
        eb   = (b[14:10] == 5'd0) ? 32'sd1 : int'(b[14:10]);
        prod = {21'd0, (a[14:10] != 5'd0), a[9:0]} * {21'd0, (b[14:10] != 5'd0), b[9:0]};
        k    = 32'sd0;
        for (int i = 0; i < 22; i++) begin
            if (prod[i]) k = i;
        end
        ee = k + ea + eb - 32'sd35;
        if (ee < 32'sd1) ee = 32'sd1;
        rs   = ee + 32'sd25 - ea - eb;
        n    = 32'd0;
        rem  = 32'd0;
        half = 32'd0;
        // rs is the shift that lands the result mantissa on an integer grid of the target exponent
        if (rs <= 32'sd0) begin
            n = prod << (-rs);
        end else begin
            n    = prod >> rs;
            rem  = prod & ((32'd1 << rs) - 32'd1);
            half = 32'd1 << (rs - 32'sd1);
            if ((rem > half) || ((rem == half) && n[0])) n = n + 32'd1;
        end
        if (n == 32'd2048) begin
            n  = 32'd1024;
            ee = ee + 32'sd1;
        end
        if ((a[14:10] == 5'h1f) || (b[14:10] == 5'h1f)) begin
            if ((a[14:10] == 5'h1f && a[9:0] != 10'd0) || (b[14:10] == 5'h1f && b[9:0] != 10'd0) ||
                (prod == 32'd0))
                r = 16'h7e00;
            else
                r = {sgn, 5'h1f, 10'd0};
        end else if (prod == 32'd0) begin
            r = {sgn, 15'd0};
        end else if (ee >= 32'sd31) begin
            r = {sgn, 5'h1f, 10'd0};
        end else begin
            r = {sgn, (n[10] ? ee[4:0] : 5'd0), n[9:0]};
        end
        return r;
    endfunction

    logic [M_LAT-1:0] vld_q;
    logic [15:0]      res_q [M_LAT];

    // Product computed into the first stage, then carried down an M_LAT-deep pipe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            for (int k = 0; k < M_LAT; k++) res_q[k] <= 16'd0;
        end else begin
            vld_q[0] <= valid_in;
            res_q[0] <= fp16_mul(a_in, b_in);
            for (int k = 1; k < M_LAT; k++) begin
                vld_q[k] <= vld_q[k-1];
                res_q[k] <= res_q[k-1];
            end
        end
    end

    assign valid_out = vld_q[M_LAT-1];
    assign prod_out  = res_q[M_LAT-1];
endmodule

module xd_skip_mul #(
    parameter int B     = 1,
    parameter int H     = 4,
    parameter int P     = 4,
    parameter int DW    = 16,
    parameter int M_LAT = 6,
    parameter int PAR_P = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [B*H*P*DW-1:0]   x_flat,
    input  logic [H*DW-1:0]       D_flat,
    output logic [B*H*P*DW-1:0]   xD_flat,
    output logic                  done
);
    localparam int BW = (B > 1) ? $clog2(B) : 1;
    localparam int HW = (H > 1) ? $clog2(H) : 1;
    localparam int PW = $clog2(P + PAR_P);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FLUSH, S_DONE} state_t;

    state_t                        state_q, state_d;
    logic [BW-1:0]                 b_q, b_d;
    logic [HW-1:0]                 h_q, h_d;
    logic [PW-1:0]                 p_q, p_d;
    logic                          done_q;
    logic [B*H*P*DW-1:0]           xd_q;
    logic [DW-1:0]                 op_d_q;
    logic [PAR_P-1:0][DW-1:0]      op_x_q;
    logic [PAR_P-1:0]              tag_vld_q [M_LAT+1];
    logic [BW-1:0]                 tag_b_q   [M_LAT+1];
    logic [HW-1:0]                 tag_h_q   [M_LAT+1];
    logic [PAR_P-1:0][PW-1:0]      tag_p_q   [M_LAT+1];

    logic                          issue_s, last_beat_s, busy_s;
    logic [PAR_P-1:0]              lane_vld_s, mul_vld_s, wr_en_s;
    logic [PAR_P-1:0][DW-1:0]      lane_x_s, mul_res_s, wr_val_s;
    int                            lane_p_s [PAR_P];
    int                            lane_g_s [PAR_P];
    int                            wr_g_s   [PAR_P];

`ifdef XD_FTZ_EN
    function automatic logic [15:0] ftz(input logic [15:0] v);
        return (v[14:10] == 5'd0) ? {v[15], 15'd0} : v;
    endfunction
`endif

    // Beat operand selection; masked lanes read element 0 so no index leaves the array.
    always_comb begin
        issue_s     = (state_q == S_CALC);
        last_beat_s = (int'(b_q) == B - 1) && (int'(h_q) == H - 1) && (int'(p_q) + PAR_P >= P);
        for (int i = 0; i < PAR_P; i++) begin
            lane_p_s[i]   = int'(p_q) + i;
            lane_vld_s[i] = issue_s && (lane_p_s[i] < P);
            if (lane_vld_s[i]) lane_g_s[i] = (int'(b_q) * H + int'(h_q)) * P + lane_p_s[i];
            else               lane_g_s[i] = 32'sd0;
            lane_x_s[i] = x_flat[lane_g_s[i]*DW +: DW];
        end
    end

    // Beat counters: p by PAR_P, then h, then b; wrap to zero after the last beat.
    always_comb begin
        b_d = b_q;
        h_d = h_q;
        p_d = p_q;
        if (issue_s) begin
            if (last_beat_s) begin
                b_d = '0;
                h_d = '0;
                p_d = '0;
            end else if (int'(p_q) + PAR_P < P) begin
                p_d = p_q + PW'(PAR_P);
            end else begin
                p_d = '0;
                if (int'(h_q) == H - 1) begin
                    h_d = '0;
                    b_d = b_q + BW'(1'b1);
                end else begin
                    h_d = h_q + HW'(1'b1);
                end
            end
        end else begin
            p_d = p_q;
        end
    end

    // Any valid tag left anywhere means a result is still on its way to xD.
    always_comb begin
        busy_s = 1'b0;
        for (int k = 0; k <= M_LAT; k++) busy_s = busy_s | (|tag_vld_q[k]);
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_CALC;  else state_d = S_IDLE;
            S_CALC:  if (last_beat_s) state_d = S_FLUSH; else state_d = S_CALC;
            S_FLUSH: if (!busy_s) state_d = S_DONE; else state_d = S_FLUSH;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State, counters and the done pulse (high the cycle after DONE).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            b_q     <= '0;
            h_q     <= '0;
            p_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            b_q     <= b_d;
            h_q     <= h_d;
            p_q     <= p_d;
            done_q  <= (state_q == S_DONE);
        end
    end

    // Operand register plus tag pipe; stage 0 lines up with the operands, stage M_LAT with the product.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_d_q <= '0;
            op_x_q <= '0;
            for (int k = 0; k <= M_LAT; k++) begin
                tag_vld_q[k] <= '0;
                tag_b_q[k]   <= '0;
                tag_h_q[k]   <= '0;
                tag_p_q[k]   <= '0;
            end
        end else begin
            op_d_q       <= D_flat[int'(h_q)*DW +: DW];
            op_x_q       <= lane_x_s;
            tag_vld_q[0] <= lane_vld_s;
            tag_b_q[0]   <= b_q;
            tag_h_q[0]   <= h_q;
            for (int i = 0; i < PAR_P; i++) tag_p_q[0][i] <= PW'(lane_p_s[i]);
            for (int k = 1; k <= M_LAT; k++) begin
                tag_vld_q[k] <= tag_vld_q[k-1];
                tag_b_q[k]   <= tag_b_q[k-1];
                tag_h_q[k]   <= tag_h_q[k-1];
                tag_p_q[k]   <= tag_p_q[k-1];
            end
        end
    end

    for (genvar i = 0; i < PAR_P; i++) begin : g_lane
        fp16_mul_wrapper #(.M_LAT(M_LAT)) u_mul (
            .clk       (clk),
            .rst       (rst),
            .valid_in  (tag_vld_q[0][i]),
            .a_in      (op_d_q),
            .b_in      (op_x_q[i]),
            .valid_out (mul_vld_s[i]),
            .prod_out  (mul_res_s[i])
        );
    end

    // Write address comes from the tag, never from the live counters.
    always_comb begin
        for (int i = 0; i < PAR_P; i++) begin
            wr_en_s[i] = mul_vld_s[i] && tag_vld_q[M_LAT][i];
            if (wr_en_s[i])
                wr_g_s[i] = (int'(tag_b_q[M_LAT]) * H + int'(tag_h_q[M_LAT])) * P + int'(tag_p_q[M_LAT][i]);
            else
                wr_g_s[i] = 32'sd0;
`ifdef XD_FTZ_EN
            wr_val_s[i] = ftz(mul_res_s[i]);
`else
            wr_val_s[i] = mul_res_s[i];
`endif
        end
    end

    // Result storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xd_q <= '0;
        end else begin
            for (int i = 0; i < PAR_P; i++) begin
                if (wr_en_s[i]) xd_q[wr_g_s[i]*DW +: DW] <= wr_val_s[i];
            end
        end
    end

    assign xD_flat = xd_q;
    assign done    = done_q;
endmodule

// File: tb/tb_xd_skip_mul.sv
// Randomized self-checking bench for xd_skip_mul; reference products come from real arithmetic.
// Two instances: P=4/PAR_P=4 (dut_a) and P=6/PAR_P=4 (dut_b).

module tb_xd_skip_mul;
    localparam int H = 4, P_A = 4, P_B = 6, M_LAT = 6;
    localparam int LAT_A = H * 1 + M_LAT + 3;
    localparam int LAT_B = H * 2 + M_LAT + 3;
`ifdef XD_FTZ_EN
    localparam logic [15:0] E_POS = 16'h0000, E_NEG = 16'h8000;
`else
    localparam logic [15:0] E_POS = 16'h0200, E_NEG = 16'h8200;
`endif

    logic clk = 1'b0;
    logic rst, start_a, start_b, done_a, done_b;
    logic [H*P_A*16-1:0] x_a, xd_a;
    logic [H*P_B*16-1:0] x_b, xd_b;
    logic [H*16-1:0]     d_a, d_b;
    int vectors = 0, errors = 0;
    int dcnt_a = 0, dcnt_b = 0;

    always #5 clk = ~clk;

    xd_skip_mul #(.B(1), .H(H), .P(P_A), .DW(16), .M_LAT(M_LAT), .PAR_P(4)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .x_flat(x_a), .D_flat(d_a), .xD_flat(xd_a), .done(done_a));
    xd_skip_mul #(.B(1), .H(H), .P(P_B), .DW(16), .M_LAT(M_LAT), .PAR_P(4)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .x_flat(x_b), .D_flat(d_b), .xD_flat(xd_b), .done(done_b));

    always @(negedge clk) begin
        if (done_a === 1'b1) dcnt_a++;
        if (done_b === 1'b1) dcnt_b++;
    end

    function automatic real pow2(input int e);
        real r = 1.0;
        if (e >= 0) for (int i = 0; i < e; i++) r = r * 2.0;
        else        for (int i = 0; i < -e; i++) r = r / 2.0;
        return r;
    endfunction

    function automatic real mag(input logic [15:0] h);
        int e = int'(h[14:10]);
        int m = int'(h[9:0]);
        if (e == 0) return real'(m) * pow2(-24);
        return real'(m + 1024) * pow2(e - 25);
    endfunction

    // Round a non-negative real to binary16 (nearest-even) with the given sign.
    function automatic logic [15:0] to_h(input logic s, input real a);
        int e;
        real q, m, fr;
        longint n;
        if (a == 0.0) return {s, 15'd0};
        if (a >= 65536.0) return {s, 5'h1f, 10'd0};
        e = 15;
        while (e > -14 && a < pow2(e)) e--;
        q  = pow2(e - 10);
        m  = a / q;
        n  = longint'($floor(m));
        fr = m - real'(n);
        if (fr > 0.5 || (fr == 0.5 && n[0])) n++;
        if (n == 2048) begin n = 1024; e++; end
        if (e > 15) return {s, 5'h1f, 10'd0};
        if (n < 1024) return {s, 5'd0, n[9:0]};
        return {s, 5'(e + 15), n[9:0]};
    endfunction

    function automatic logic [15:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] r;
        r = to_h(a[15] ^ b[15], mag(a) * mag(b));
`ifdef XD_FTZ_EN
        if (r[14:10] == 5'd0) r = {r[15], 15'd0};
`endif
        return r;
    endfunction

    function automatic logic [15:0] rand_h();
        return {1'($urandom_range(0, 1)), 5'($urandom_range(0, 30)), 10'($urandom_range(0, 1023))};
    endfunction

    function automatic logic [15:0] exp_a(input int g);
        return ref_mul(d_a[((g / P_A) % H)*16 +: 16], x_a[g*16 +: 16]);
    endfunction

    function automatic logic [15:0] exp_b(input int g);
        return ref_mul(d_b[((g / P_B) % H)*16 +: 16], x_b[g*16 +: 16]);
    endfunction

    // Pulse start, then count cycles to done; optional extra start pulses at chosen cycle offsets.
    task automatic run_batch(input int sel, input int inj0, input int inj1, input int inj2, output int lat);
        int c = 0;
        bit seen = 1'b0;
        if (sel == 0) start_a = 1'b1; else start_b = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        start_b = 1'b0;
        while (!seen && c < 300) begin
            @(posedge clk);
            #1;
            c++;
            seen = (sel == 0) ? done_a : done_b;
            if (!seen && (c == inj0 || c == inj1 || c == inj2)) begin
                if (sel == 0) start_a = 1'b1; else start_b = 1'b1;
            end else begin
                start_a = 1'b0;
                start_b = 1'b0;
            end
        end
        start_a = 1'b0;
        start_b = 1'b0;
        lat = seen ? c : -1;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        vectors++; if (xd_a !== '0) begin errors++; $display("FAIL reset_xd_a: got %h want 0", xd_a); end
        vectors++; if (xd_b !== '0) begin errors++; $display("FAIL reset_xd_b: got %h want 0", xd_b); end
        vectors++; if (done_a !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done_a); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_ones();
        int lat, n0;
        for (int h = 0; h < H; h++) d_a[h*16 +: 16] = 16'h4000;
        for (int g = 0; g < H*P_A; g++) x_a[g*16 +: 16] = 16'h3C00;
        n0 = dcnt_a;
        run_batch(0, -1, -1, -1, lat);
        vectors++; if (lat != LAT_A) begin errors++; $display("FAIL ones_latency: got %0d want %0d", lat, LAT_A); end
        for (int g = 0; g < H*P_A; g++) begin
            vectors++;
            if (xd_a[g*16 +: 16] !== 16'h4000) begin errors++; $display("FAIL ones_xd[%0d]: got %h want 4000", g, xd_a[g*16 +: 16]); end
        end
        repeat (4) @(negedge clk);
        vectors++; if (dcnt_a - n0 != 1) begin errors++; $display("FAIL ones_done_pulses: got %0d want 1", dcnt_a - n0); end
    endtask

    task automatic test_negate();
        int lat;
        for (int h = 0; h < H; h++) d_a[h*16 +: 16] = (h == 2) ? 16'h0000 : 16'hBC00;
        for (int g = 0; g < H*P_A; g++) x_a[g*16 +: 16] = 16'h4200;
        @(negedge clk);
        run_batch(0, -1, -1, -1, lat);
        vectors++; if (lat != LAT_A) begin errors++; $display("FAIL neg_latency: got %0d want %0d", lat, LAT_A); end
        for (int g = 0; g < H*P_A; g++) begin
            vectors++;
            if (xd_a[g*16 +: 16] !== ((g / P_A == 2) ? 16'h0000 : 16'hC200)) begin
                errors++; $display("FAIL neg_xd[%0d]: got %h want %h", g, xd_a[g*16 +: 16], (g / P_A == 2) ? 16'h0000 : 16'hC200);
            end
        end
    endtask

    task automatic test_random_a();
        int lat;
        for (int r = 0; r < 6; r++) begin
            for (int h = 0; h < H; h++) d_a[h*16 +: 16] = rand_h();
            for (int g = 0; g < H*P_A; g++) x_a[g*16 +: 16] = rand_h();
            @(negedge clk);
            run_batch(0, -1, -1, -1, lat);
            vectors++; if (lat != LAT_A) begin errors++; $display("FAIL rand_a_latency: got %0d want %0d", lat, LAT_A); end
            for (int g = 0; g < H*P_A; g++) begin
                vectors++;
                if (xd_a[g*16 +: 16] !== exp_a(g)) begin
                    errors++; $display("FAIL rand_a_xd[%0d]: D=%h x=%h got %h want %h", g, d_a[((g / P_A) % H)*16 +: 16], x_a[g*16 +: 16], xd_a[g*16 +: 16], exp_a(g));
                end
            end
        end
    endtask

    task automatic test_p6();
        int lat;
        logic [15:0] pv [6];
        pv = '{16'h0000, 16'h3C00, 16'h4000, 16'h4200, 16'h4400, 16'h4500};
        for (int h = 0; h < H; h++) d_b[h*16 +: 16] = 16'h3C00;
        for (int g = 0; g < H*P_B; g++) x_b[g*16 +: 16] = pv[g % P_B];
        @(negedge clk);
        run_batch(1, -1, -1, -1, lat);
        vectors++; if (lat != LAT_B) begin errors++; $display("FAIL p6_latency: got %0d want %0d", lat, LAT_B); end
        for (int g = 0; g < H*P_B; g++) begin
            vectors++;
            if (xd_b[g*16 +: 16] !== pv[g % P_B]) begin errors++; $display("FAIL p6_xd[%0d]: got %h want %h", g, xd_b[g*16 +: 16], pv[g % P_B]); end
        end
        for (int r = 0; r < 3; r++) begin
            for (int h = 0; h < H; h++) d_b[h*16 +: 16] = rand_h();
            for (int g = 0; g < H*P_B; g++) x_b[g*16 +: 16] = rand_h();
            @(negedge clk);
            run_batch(1, -1, -1, -1, lat);
            vectors++; if (lat != LAT_B) begin errors++; $display("FAIL p6_rand_latency: got %0d want %0d", lat, LAT_B); end
            for (int g = 0; g < H*P_B; g++) begin
                vectors++;
                if (xd_b[g*16 +: 16] !== exp_b(g)) begin errors++; $display("FAIL p6_rand_xd[%0d]: got %h want %h", g, xd_b[g*16 +: 16], exp_b(g)); end
            end
        end
    endtask

    task automatic test_back_to_back();
        int lat, n0;
        for (int h = 0; h < H; h++) d_a[h*16 +: 16] = 16'h4000;
        for (int g = 0; g < H*P_A; g++) x_a[g*16 +: 16] = 16'h3C00;
        n0 = dcnt_a;
        @(negedge clk);
        // extra starts land in CALC (2), FLUSH (8) and the DONE cycle (LAT_A-1)
        run_batch(0, 2, 8, LAT_A - 1, lat);
        vectors++; if (lat != LAT_A) begin errors++; $display("FAIL b2b_first_latency: got %0d want %0d", lat, LAT_A); end
        for (int g = 0; g < H*P_A; g++) begin
            vectors++;
            if (xd_a[g*16 +: 16] !== 16'h4000) begin errors++; $display("FAIL b2b_first_xd[%0d]: got %h want 4000", g, xd_a[g*16 +: 16]); end
        end
        for (int h = 0; h < H; h++) d_a[h*16 +: 16] = rand_h();
        for (int g = 0; g < H*P_A; g++) x_a[g*16 +: 16] = rand_h();
        run_batch(0, -1, -1, -1, lat);
        vectors++; if (lat != LAT_A) begin errors++; $display("FAIL b2b_second_latency: got %0d want %0d", lat, LAT_A); end
        for (int g = 0; g < H*P_A; g++) begin
            vectors++;
            if (xd_a[g*16 +: 16] !== exp_a(g)) begin errors++; $display("FAIL b2b_second_xd[%0d]: got %h want %h", g, xd_a[g*16 +: 16], exp_a(g)); end
        end
        repeat (4) @(negedge clk);
        vectors++; if (dcnt_a - n0 != 2) begin errors++; $display("FAIL b2b_done_pulses: got %0d want 2", dcnt_a - n0); end
    endtask

    task automatic test_reset_mid();
        int lat, n0;
        for (int h = 0; h < H; h++) d_a[h*16 +: 16] = rand_h();
        for (int g = 0; g < H*P_A; g++) x_a[g*16 +: 16] = rand_h();
        @(negedge clk);
        start_a = 1'b1;
        @(posedge clk);
        #1 start_a = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        vectors++; if (xd_a !== '0) begin errors++; $display("FAIL midrst_xd: got %h want 0", xd_a); end
        vectors++; if (done_a !== 1'b0) begin errors++; $display("FAIL midrst_done: got %b want 0", done_a); end
        @(negedge clk);
        rst = 1'b0;
        n0 = dcnt_a;
        for (int c = 0; c < M_LAT + 5; c++) begin
            @(posedge clk);
            #1;
            vectors++; if (xd_a !== '0) begin errors++; $display("FAIL midrst_quiet_xd: cycle %0d got %h want 0", c, xd_a); end
        end
        vectors++; if (dcnt_a != n0) begin errors++; $display("FAIL midrst_quiet_done: got %0d pulses want 0", dcnt_a - n0); end
        @(negedge clk);
        run_batch(0, -1, -1, -1, lat);
        vectors++; if (lat != LAT_A) begin errors++; $display("FAIL midrst_restart_latency: got %0d want %0d", lat, LAT_A); end
        for (int g = 0; g < H*P_A; g++) begin
            vectors++;
            if (xd_a[g*16 +: 16] !== exp_a(g)) begin errors++; $display("FAIL midrst_restart_xd[%0d]: got %h want %h", g, xd_a[g*16 +: 16], exp_a(g)); end
        end
    endtask

    task automatic test_subnormal();
        int lat;
        for (int h = 0; h < H; h++) d_a[h*16 +: 16] = (h == 1) ? 16'h8400 : 16'h0400;
        for (int g = 0; g < H*P_A; g++) x_a[g*16 +: 16] = 16'h3800;
        @(negedge clk);
        run_batch(0, -1, -1, -1, lat);
        vectors++; if (lat != LAT_A) begin errors++; $display("FAIL sub_latency: got %0d want %0d", lat, LAT_A); end
        for (int g = 0; g < H*P_A; g++) begin
            vectors++;
            if (xd_a[g*16 +: 16] !== ((g / P_A == 1) ? E_NEG : E_POS)) begin
                errors++; $display("FAIL sub_xd[%0d]: got %h want %h", g, xd_a[g*16 +: 16], (g / P_A == 1) ? E_NEG : E_POS);
            end
        end
    endtask

    initial begin
        rst     = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        x_a     = '0;
        x_b     = '0;
        d_a     = '0;
        d_b     = '0;
        test_reset();
        test_ones();
        test_negate();
        test_random_a();
        test_p6();
        test_back_to_back();
        test_reset_mid();
        test_subnormal();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
